// File: rtl/jk_machine_sequencer.sv
// rtl/jk_machine_sequencer.sv - drives the 3-bit JK machine through a stored serial test pattern
module jk_machine_sequencer #(
  parameter int W  = 16,
  parameter int LW = 5
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [W-1:0]  PATTERN,
  input  logic [LW-1:0] LEN,
  input  logic          F_IN,
  output logic          X_OUT,
  output logic          M_RESET,
  output logic          BUSY,
  output logic          DONE,
  output logic [LW-1:0] HITS,
  output logic [LW-1:0] FIRST
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [LW-1:0] LEN_MAX  = LW'(W);
  localparam logic [LW-1:0] NO_FIRST = '1;
  localparam logic [LW-1:0] ONE      = LW'(1);

  state_t        state_q, state_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] hits_q, hits_d;
  logic [LW-1:0] first_q, first_d;
  logic          x_q, x_d;
  logic          mres_q, mres_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [LW-1:0] len_clamped;
  logic          sample;
  logic [LW-1:0] step;

  // Requested length limited to the pattern register width
  always_comb begin
    len_clamped = (LEN > LEN_MAX) ? LEN_MAX : LEN;
  end

  // Next-state, step bookkeeping and F sampling with step attribution
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    len_d   = len_q;
    hits_d  = hits_q;
    first_d = first_q;
    sample  = 1'b0;
    step    = '0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          pat_d   = PATTERN;
          len_d   = len_clamped;
          hits_d  = '0;
          first_d = NO_FIRST;
          idx_d   = '0;
          state_d = (len_clamped == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        idx_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        pat_d = pat_q >> 1;
        idx_d = idx_q + ONE;
        // F in the first RUN cycle shows the freshly cleared machine
        if (idx_q != '0) begin
          sample = 1'b1;
          step   = idx_q - ONE;
        end
        if (idx_q == len_q - ONE) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The last step's response only appears after the final shift
        sample  = 1'b1;
        step    = len_q - ONE;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (sample && F_IN) begin
      hits_d = hits_q + ONE;
      if (first_q == NO_FIRST) begin
        first_d = step;
      end
    end
  end

  // Output values for the coming cycle, derived from next state and next pattern only
  always_comb begin
    x_d    = (state_d == S_RUN) ? pat_d[0] : 1'b0;
    mres_d = (state_d == S_CLEAR);
    busy_d = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // Sequencer state and registered outputs; reset aborts any run in progress
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      hits_q  <= '0;
      first_q <= NO_FIRST;
      x_q     <= 1'b0;
      mres_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      hits_q  <= hits_d;
      first_q <= first_d;
      x_q     <= x_d;
      mres_q  <= mres_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign X_OUT   = x_q;
  assign M_RESET = mres_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign HITS    = hits_q;
  assign FIRST   = first_q;

endmodule

// File: tb/tb_jk_machine_sequencer.sv
// tb/tb_jk_machine_sequencer.sv - self-checking bench for jk_machine_sequencer
module tb_jk_machine_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        START = 1'b0;
  logic [15:0] PATTERN = '0;
  logic [4:0]  LEN = '0;
  logic        F_IN;
  logic        X_OUT, M_RESET, BUSY, DONE;
  logic [4:0]  HITS, FIRST;

  logic        f_stub = 1'b0;
  logic        use_machine = 1'b0;
  logic [2:0]  ms;
  logic        f_mach;

  int tests = 0;
  int fails = 0;

  jk_machine_sequencer #(.W(16), .LW(5)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .PATTERN(PATTERN), .LEN(LEN),
    .F_IN(F_IN), .X_OUT(X_OUT), .M_RESET(M_RESET), .BUSY(BUSY), .DONE(DONE),
    .HITS(HITS), .FIRST(FIRST)
  );

  always #5 CLK = ~CLK;

  // Stand-in 3-bit machine: remembers the last three x values, F flags the sequence 1,0,1
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)       ms <= 3'b000;
    else if (M_RESET) ms <= 3'b000;
    else              ms <= {ms[1:0], X_OUT};
  end
  assign f_mach = (ms == 3'b101);
  assign F_IN   = use_machine ? f_mach : f_stub;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: F after step i is 1 when steps i-2,i-1,i carried 1,0,1 (steps before 0 read as 0)
  task automatic ref_model(input logic [15:0] p, input logic [4:0] l,
                           output logic [4:0] h, output logic [4:0] f);
    int n;
    int cnt;
    int fi;
    logic a, b, c;
    n = (l > 5'd16) ? 16 : int'(l);
    cnt = 0;
    fi = 31;
    for (int i = 0; i < n; i++) begin
      a = p[i];
      b = 1'b0;
      c = 1'b0;
      if (i >= 1) b = p[i-1];
      if (i >= 2) c = p[i-2];
      if (c && !b && a) begin
        cnt++;
        if (fi == 31) fi = i;
      end
    end
    h = 5'(cnt);
    f = 5'(fi);
  endtask

  // Start a run; trace index k is cycle t+k where t is the acceptance cycle
  task automatic do_run(input logic [15:0] p, input logic [4:0] l, input logic [31:0] fmask,
                        input bit hold, output int done_at, output int done_cnt,
                        output logic [63:0] xtr, output logic [63:0] mtr, output logic [63:0] btr,
                        output logic [4:0] hd, output logic [4:0] fd);
    done_at = -1;
    done_cnt = 0;
    xtr = '0;
    mtr = '0;
    btr = '0;
    hd = '0;
    fd = '0;
    @(negedge CLK);
    PATTERN = p;
    LEN = l;
    START = 1'b1;
    f_stub = fmask[0];
    @(posedge CLK);
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      xtr[k] = X_OUT;
      mtr[k] = M_RESET;
      btr[k] = BUSY;
      if (DONE) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          hd = HITS;
          fd = FIRST;
        end
      end
      f_stub = (k < 32) ? fmask[k] : 1'b0;
      if (!hold) START = 1'b0;
      if (done_at >= 0 && k >= done_at + 3) break;
    end
    f_stub = 1'b0;
  endtask

  typedef struct {
    logic [15:0] p;
    logic [4:0]  l;
    logic [31:0] fm;
    int          exp_done;
    logic [4:0]  exp_hits;
    logic [4:0]  exp_first;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          done_at, done_cnt, w;
    logic [63:0] xtr, mtr, btr, bexp, mexp;
    logic [4:0]  hd, fd, eh, ef;
    logic [15:0] rp;
    logic [4:0]  rl;

    vecs[0] = '{16'h00B5, 5'd8,  32'h0000_0000, 11, 5'd0, 5'h1F};
    vecs[1] = '{16'h0000, 5'd5,  32'h0000_0094, 8,  5'd2, 5'd1};
    vecs[2] = '{16'hFFFF, 5'd0,  32'hFFFF_FFFF, 1,  5'd0, 5'h1F};
    vecs[3] = '{16'h1234, 5'd20, 32'h0000_0000, 19, 5'd0, 5'h1F};
    vecs[4] = '{16'hA5A5, 5'd16, 32'h0004_0000, 19, 5'd1, 5'd15};
    vecs[5] = '{16'h0001, 5'd1,  32'h0000_000C, 4,  5'd1, 5'd0};
    vecs[6] = '{16'h000F, 5'd4,  32'hFFFF_FFFF, 7,  5'd4, 5'd0};
    vecs[7] = '{16'hFFFF, 5'd31, 32'h0004_0000, 19, 5'd1, 5'd15};

    // Reset values
    #3 RESET = 1'b0;
    #1;
    check("rst_x", 32'(X_OUT), 0);
    check("rst_mres", 32'(M_RESET), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_done", 32'(DONE), 0);
    check("rst_hits", 32'(HITS), 0);
    check("rst_first", 32'(FIRST), 32'h1F);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    // Reset asserted mid-run takes effect before the next clock edge
    @(negedge CLK);
    PATTERN = 16'hFFFF;
    LEN = 5'd8;
    START = 1'b1;
    f_stub = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    check("mid_x", 32'(X_OUT), 1);
    check("mid_busy", 32'(BUSY), 1);
    check("mid_hits", 32'(HITS), 2);
    #2 RESET = 1'b0;
    #1;
    check("arst_x", 32'(X_OUT), 0);
    check("arst_busy", 32'(BUSY), 0);
    check("arst_hits", 32'(HITS), 0);
    check("arst_first", 32'(FIRST), 32'h1F);
    check("arst_done", 32'(DONE), 0);
    @(negedge CLK);
    RESET = 1'b1;
    f_stub = 1'b0;

    // Table-driven runs with stubbed F
    for (int v = 0; v < 8; v++) begin
      do_run(vecs[v].p, vecs[v].l, vecs[v].fm, 1'b0, done_at, done_cnt, xtr, mtr, btr, hd, fd);
      check($sformatf("v%0d_done_at", v), 32'(done_at), 32'(vecs[v].exp_done));
      check($sformatf("v%0d_done_cnt", v), 32'(done_cnt), 1);
      check($sformatf("v%0d_hits", v), 32'(hd), 32'(vecs[v].exp_hits));
      check($sformatf("v%0d_first", v), 32'(fd), 32'(vecs[v].exp_first));
      bexp = '0;
      for (int k = 1; k < vecs[v].exp_done; k++) bexp[k] = 1'b1;
      check($sformatf("v%0d_busy", v), 32'(btr[24:1]), 32'(bexp[24:1]));
      mexp = '0;
      if (vecs[v].exp_done > 1) mexp[1] = 1'b1;
      check($sformatf("v%0d_mres", v), 32'(mtr[24:1]), 32'(mexp[24:1]));
      check($sformatf("v%0d_hits_hold", v), 32'(HITS), 32'(vecs[v].exp_hits));
      if (v == 0) begin
        check("v0_x_seq", 32'(xtr[9:2]), 32'hB5);
        check("v0_x_drain", 32'(xtr[10]), 0);
      end
    end

    // START held high: one run, the next begins from IDLE two cycles after DONE
    do_run(16'h0005, 5'd3, 32'h0, 1'b1, done_at, done_cnt, xtr, mtr, btr, hd, fd);
    check("hold_done_at", 32'(done_at), 6);
    check("hold_done_cnt", 32'(done_cnt), 1);
    check("hold_mres", 32'(mtr[8:1]), 32'h81);
    START = 1'b0;
    w = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge CLK);
      if (DONE) begin
        w = k;
        break;
      end
    end
    check("hold_second_done", 32'(w), 4);
    repeat (2) @(negedge CLK);

    // Random patterns against the stand-in machine
    use_machine = 1'b1;
    for (int r = 0; r < 200; r++) begin
      rp = 16'($urandom);
      rl = 5'($urandom_range(0, 20));
      ref_model(rp, rl, eh, ef);
      do_run(rp, rl, 32'h0, 1'b0, done_at, done_cnt, xtr, mtr, btr, hd, fd);
      check($sformatf("rnd%0d_hits p=%h l=%0d", r, rp, rl), 32'(hd), 32'(eh));
      check($sformatf("rnd%0d_first p=%h l=%0d", r, rp, rl), 32'(fd), 32'(ef));
    end
    use_machine = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jk_machine_sequencer.md
Name: jk_machine_sequencer

Overview:
- Controller that drives the 3-bit JK-flip-flop state machine (inputs x, CLK, RESET; output F) through a stored serial test pattern.
- On START it captures a pattern word and length, clears the machine with a one-cycle reset pulse, then shifts the pattern onto the machine's x input LSB first, one bit per clock.
- It monitors F, counts assertions and records the bit index of the first one.
- It sits beside the machine as its only driver of x and of the machine reset.

Parameters:
- W, 16: maximum pattern length in bits.
- LW, 5: width of the length, count and index fields; must satisfy 2^LW > W.

Ports:
- CLK  input  1  : system clock, rising edge.
- RESET  input  1  : asynchronous, active-low reset.
- START  input  1  : start request, sampled only in IDLE.
- PATTERN  input  W  : bit i is applied to the machine at step i.
- LEN  input  LW  : number of steps. 0 means an empty run; values above W are clamped to W.
- F_IN  input  1  : the machine's F output.
- X_OUT  output  1  : drives the machine's x input.
- M_RESET  output  1  : active-high reset pulse to the machine.
- BUSY  output  1  : high from the cycle after START acceptance through DRAIN.
- DONE  output  1  : one-cycle completion pulse.
- HITS  output  LW  : number of steps after which F_IN was 1.
- FIRST  output  LW  : lowest step index that produced F_IN=1; all ones if HITS=0.

Behaviour:
- States: IDLE, CLEAR, RUN, DRAIN, DONE. Step counter idx (LW bits). Pattern shift register pat (W bits).
- RESET low, asynchronous:
  - state=IDLE, idx=0, pat=0.
  - X_OUT=0, M_RESET=0, BUSY=0, DONE=0, HITS=0, FIRST=all ones.
  - This takes effect immediately, including mid-run; a partial result is discarded.
- IDLE:
  - On START=1, capture PATTERN into pat and min(LEN,W) into the length register, and clear HITS to 0 and FIRST to all ones.
  - If the clamped length is 0, go to DONE; otherwise go to CLEAR.
  - START is ignored in every other state.
- CLEAR (1 cycle): M_RESET=1, X_OUT=0, idx=0, then go to RUN.
- RUN:
  - X_OUT = pat[0].
  - At each edge, pat shifts right by one (zero fill) and idx increments.
  - After the edge where idx = len-1, go to DRAIN.
- Sampling rule:
  - The machine registers x at the edge ending step i, so F_IN observed in the following cycle belongs to step i.
  - F_IN is sampled in RUN cycles with idx>0 (attributed to step idx-1) and in the DRAIN cycle (attributed to step len-1).
  - F_IN in the first RUN cycle reflects the freshly cleared machine and is ignored.
- Hit update, applied when the sampled F_IN=1:
  - HITS increments by 1. HITS cannot exceed len, so no overflow occurs.
  - If FIRST is all ones, FIRST takes the attributed step index.
- DRAIN (1 cycle): X_OUT=0, final sample, then go to DONE.
- DONE (1 cycle): DONE=1, BUSY=0, then go to IDLE.
- Output decoding:
  - X_OUT, M_RESET, BUSY and DONE are decoded from registered state and pat only; they do not depend combinationally on START or F_IN.
  - HITS and FIRST hold their values until the next START is accepted.
- Latency: START accepted in cycle t gives CLEAR at t+1, RUN at t+2 .. t+len+1, DRAIN at t+len+2, and DONE at t+len+3. For len=0, DONE is at t+1 and M_RESET is never pulsed.
- F_IN is treated as synchronous to CLK, since the machine is clocked by the same CLK; no synchroniser is required.

Test Plan:
- Reset: assert RESET low mid-RUN with LEN=8 → outputs return to reset values in the same cycle and X_OUT=0. After release, a new START runs normally.
- Stub F_IN, LEN=5, START accepted at cycle t, F_IN=1 only at t+2, t+4 and t+7:
  - The t+2 sample is ignored.
  - Expect DONE at t+8, HITS=2 and FIRST=1; the t+7 hit is attributed to step 4.
- X_OUT sequence: PATTERN=16'h00B5, LEN=8 → X_OUT over cycles t+2..t+9 = 1,0,1,0,1,1,0,1, then 0 in DRAIN. M_RESET=1 only at t+1.
- Edge lengths:
  - LEN=0 → DONE at t+1, HITS=0, FIRST=5'h1F, M_RESET stays 0.
  - LEN=20 → clamped to 16, DONE at t+19.
- Busy protection and integration:
  - START held high throughout a run with LEN=3 → exactly one run; the next run starts only from IDLE, two cycles after DONE.
  - Connect the real 3-bit machine and compare HITS and FIRST against a bench reference model over 200 random patterns.
